fifo_regfile: RTL and testbench

Parametrised synchronous FIFO built on a register-file array of WIDTH-bit words, DEPTH entries deep. It generalises the fixed 5-bit select-enabled register into an addressed storage array with write/read pointers, occupancy tracking, status flags and error pulses. It sits between a producer and a consumer in the same clock domain and is the FIFO core of the design.

---
 rtl/fifo_regfile.sv | 96 +++++++++
 tb/tb_fifo_regfile.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fifo_regfile.sv
// Synchronous FIFO over a register-file array with count-based full/empty,
// registered read data and one-cycle overflow/underflow pulses.
module fifo_regfile #(
    parameter  int WIDTH = 5,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] dout_reg;
    logic             full_reg;
    logic             empty_reg;
    logic             overflow_reg;
    logic             underflow_reg;
    logic             wr_acc;
    logic             rd_acc;

    // A write into a full FIFO is allowed only when a read frees a slot on the same edge.
    always_comb begin
        wr_acc = wr_en & (~full_reg | rd_en);
        rd_acc = rd_en & ~empty_reg;
    end

    always_comb begin
        count_next = count_reg;
        if (wr_acc && !rd_acc) begin
            count_next = count_reg + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_next = count_reg - CW'(1);
        end
    end

    // Each entry is its own register; a read of the same entry sees the old word.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (clear) begin
                    mem_reg[gi] <= '0;
                end else if (wr_acc && (wr_ptr_reg == AW'(gi))) begin
                    mem_reg[gi] <= din;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            dout_reg      <= '0;
            full_reg      <= 1'b0;
            empty_reg     <= 1'b1;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
                dout_reg   <= mem_reg[rd_ptr_reg];
            end
            count_reg     <= count_next;
            full_reg      <= (count_next == CW'(DEPTH));
            empty_reg     <= (count_next == '0);
            overflow_reg  <= wr_en & ~wr_acc;
            underflow_reg <= rd_en & ~rd_acc;
        end
    end

    assign dout      = dout_reg;
    assign full      = full_reg;
    assign empty     = empty_reg;
    assign count     = count_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_fifo_regfile.sv
// Directed bench for fifo_regfile (WIDTH=5, DEPTH=4): reset, fill/drain,
// error pulses, simultaneous requests at the boundaries, wrap-around and mid-stream clear.
module tb_fifo_regfile;

    localparam int WIDTH = 5;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             clear;
    logic             wr_en;
    logic [WIDTH-1:0] din;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    int n_assert = 0;
    int n_fail   = 0;

    fifo_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .clear     (clear),
        .wr_en     (wr_en),
        .din       (din),
        .rd_en     (rd_en),
        .dout      (dout),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock with the given requests; outputs are sampled 1 ns after the edge.
    task automatic step(input logic w, input logic r, input logic [WIDTH-1:0] d);
        wr_en = w;
        rd_en = r;
        din   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] e_cnt,
                             input logic e_full, input logic e_empty);
        chk({tag, "_count"}, 32'(count), e_cnt);
        chk({tag, "_full"},  32'(full),  32'(e_full));
        chk({tag, "_empty"}, 32'(empty), 32'(e_empty));
    endtask

    initial begin
        clear = 1'b1;
        wr_en = 1'b1;
        rd_en = 1'b1;
        din   = 5'h1F;

        // Reset held two cycles with both requests active.
        step(1'b1, 1'b1, 5'h1F);
        step(1'b1, 1'b1, 5'h1F);
        chk("rst_dout", 32'(dout), 32'h0);
        chk_state("rst", 0, 1'b0, 1'b1);
        chk("rst_ovf", 32'(overflow), 32'h0);
        chk("rst_udf", 32'(underflow), 32'h0);
        clear = 1'b0;

        // Fill.
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b0, 5'(i));
            chk($sformatf("fill%0d_count", i), 32'(count), 32'(i));
        end
        chk_state("full", 4, 1'b1, 1'b0);

        // Overflow with write alone at full.
        step(1'b1, 1'b0, 5'h1F);
        chk("ovf_pulse", 32'(overflow), 32'h1);
        chk_state("ovf", 4, 1'b1, 1'b0);
        step(1'b0, 1'b0, 5'h00);
        chk("ovf_clear", 32'(overflow), 32'h0);

        // Drain in order.
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b1, 5'h00);
            chk($sformatf("drain%0d_dout", i), 32'(dout), 32'(i));
        end
        chk_state("drained", 0, 1'b0, 1'b1);

        // Underflow at empty.
        step(1'b0, 1'b1, 5'h00);
        chk("udf_pulse", 32'(underflow), 32'h1);
        chk("udf_dout", 32'(dout), 32'h04);
        chk_state("udf", 0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 5'h00);
        chk("udf_clear", 32'(underflow), 32'h0);

        // Empty with both requests: write only, read rejected.
        step(1'b1, 1'b1, 5'h0A);
        chk("se_udf", 32'(underflow), 32'h1);
        chk("se_dout", 32'(dout), 32'h04);
        chk_state("se", 1, 1'b0, 1'b0);

        step(1'b1, 1'b0, 5'h0B);
        step(1'b1, 1'b0, 5'h0C);
        step(1'b1, 1'b0, 5'h0D);
        chk_state("refill", 4, 1'b1, 1'b0);

        // Full with both requests: oldest word out, new word in.
        step(1'b1, 1'b1, 5'h15);
        chk("sf_dout", 32'(dout), 32'h0A);
        chk("sf_ovf", 32'(overflow), 32'h0);
        chk_state("sf", 4, 1'b1, 1'b0);
        step(1'b0, 1'b1, 5'h00);
        chk("sf_rd1", 32'(dout), 32'h0B);
        step(1'b0, 1'b1, 5'h00);
        chk("sf_rd2", 32'(dout), 32'h0C);
        step(1'b0, 1'b1, 5'h00);
        chk("sf_rd3", 32'(dout), 32'h0D);
        step(1'b0, 1'b1, 5'h00);
        chk("sf_rd4", 32'(dout), 32'h15);
        chk_state("sf_end", 0, 1'b0, 1'b1);

        // Wrap-around: hold count at 2 while streaming 00..09 through.
        step(1'b1, 1'b0, 5'h1E);
        step(1'b1, 1'b0, 5'h1D);
        for (int i = 0; i < 10; i++) begin
            logic [WIDTH-1:0] e;
            step(1'b1, 1'b1, 5'(i));
            e = (i == 0) ? 5'h1E : (i == 1) ? 5'h1D : 5'(i - 2);
            chk($sformatf("wrap%0d_dout", i), 32'(dout), 32'(e));
            chk($sformatf("wrap%0d_count", i), 32'(count), 32'h2);
        end
        step(1'b0, 1'b1, 5'h00);
        chk("wrap_tail0", 32'(dout), 32'h08);
        step(1'b0, 1'b1, 5'h00);
        chk("wrap_tail1", 32'(dout), 32'h09);
        chk_state("wrap_end", 0, 1'b0, 1'b1);

        // Clear mid-stream at count 3 with a write pending.
        step(1'b1, 1'b0, 5'h11);
        step(1'b1, 1'b0, 5'h12);
        step(1'b1, 1'b0, 5'h13);
        chk_state("pre_clr", 3, 1'b0, 1'b0);
        clear = 1'b1;
        step(1'b1, 1'b0, 5'h1F);
        clear = 1'b0;
        chk_state("clr", 0, 1'b0, 1'b1);
        chk("clr_dout", 32'(dout), 32'h0);
        step(1'b1, 1'b0, 5'h07);
        chk_state("post_wr", 1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5'h00);
        chk("post_rd", 32'(dout), 32'h07);
        chk_state("post_rd", 0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
